// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline latch and fetch range guard.
// A fetch from outside instruction memory parks the unit in HALT until reset.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter int unsigned MEM_WORDS = 128
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] RedirectTarget,
   input  logic [31:0] Instruction,
   output logic [31:0] Address,
   output logic [31:0] IFID_Instruction,
   output logic [31:0] IFID_PCPlus4,
   output logic        IFID_Valid,
   output logic        FetchFault,
   output logic [31:0] FetchCount
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   localparam logic [31:0] FETCH_LIMIT = 32'd4 * MEM_WORDS;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pcp4;
   logic        r_ifid_valid;
   logic        r_fault;
   logic [31:0] r_count;

   logic [31:0] w_pc_plus4;
   logic        w_pc_legal;
   logic [31:0] w_redirect_pc;

   assign w_pc_plus4    = r_pc + 32'd4;
   assign w_pc_legal    = (r_pc < FETCH_LIMIT);
   // Redirect targets are word-aligned by dropping the two low bits.
   assign w_redirect_pc = RedirectTarget & 32'hFFFF_FFFC;

   // Single-process FSM owning PC, IF/ID latch, sticky fault flag and fetch counter.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state      <= ST_RUN;
         r_pc         <= RESET_PC;
         r_ifid_instr <= 32'h0000_0000;
         r_ifid_pcp4  <= 32'h0000_0000;
         r_ifid_valid <= 1'b0;
         r_fault      <= 1'b0;
         r_count      <= 32'h0000_0000;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (Redirect) begin
                  r_pc         <= w_redirect_pc;
                  r_ifid_instr <= 32'h0000_0000;
                  r_ifid_valid <= 1'b0;
               end else if (Stall) begin
                  r_pc         <= r_pc;
               end else if (!w_pc_legal) begin
                  // Out-of-range fetch: squash IF/ID and park until reset.
                  r_state      <= ST_HALT;
                  r_ifid_instr <= 32'h0000_0000;
                  r_ifid_valid <= 1'b0;
                  r_fault      <= 1'b1;
               end else begin
                  r_pc         <= w_pc_plus4;
                  r_ifid_instr <= Instruction;
                  r_ifid_pcp4  <= w_pc_plus4;
                  r_ifid_valid <= 1'b1;
                  r_count      <= r_count + 32'd1;
               end
            end
            ST_HALT: begin
               r_ifid_instr <= 32'h0000_0000;
               r_ifid_valid <= 1'b0;
            end
            default: begin
               r_state      <= ST_HALT;
               r_ifid_instr <= 32'h0000_0000;
               r_ifid_valid <= 1'b0;
               r_fault      <= 1'b1;
            end
         endcase
      end
   end

   assign Address          = r_pc;
   assign IFID_Instruction = r_ifid_instr;
   assign IFID_PCPlus4     = r_ifid_pcp4;
   assign IFID_Valid       = r_ifid_valid;
   assign FetchFault       = r_fault;
   assign FetchCount       = r_count;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 Parameter MEM_WORDS, 128, instruction memory depth in 32-bit words; legal fetch addresses are 0 to 4*MEM_WORDS-4.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Stall  input  1  hold PC and IF/ID contents.
REQ-006 Redirect  input  1  branch/jump taken; load RedirectTarget into PC.
REQ-007 RedirectTarget  input  32  new fetch address.
REQ-008 Instruction  input  32  word returned combinationally by instruction memory for Address.
REQ-009 Address  output  32  fetch address to instruction memory; equals PC.
REQ-010 IFID_Instruction  output  32  registered fetched instruction.
REQ-011 IFID_PCPlus4  output  32  registered PC+4 of that instruction.
REQ-012 IFID_Valid  output  1  IF/ID holds a real instruction.
REQ-013 FetchFault  output  1  sticky: PC left legal range.
REQ-014 FetchCount  output  32  count of instructions accepted into IF/ID.

Function
REQ-015 Two-state FSM: RUN, HALT; reset enters RUN.
REQ-016 Address SHALL be driven directly from the PC register, no combinational path from Stall/Redirect.
REQ-017 RUN, Redirect=0, Stall=0: PC <= PC+4 (modulo 2^32); IF/ID <= {Instruction, PC+4}; IFID_Valid <= 1; FetchCount <= FetchCount+1.
REQ-018 RUN, Stall=1, Redirect=0: PC, IF/ID, IFID_Valid, FetchCount all hold.
REQ-019 RUN, Redirect=1 (Stall ignored): PC <= {RedirectTarget[31:2], 2'b00}; IFID_Instruction <= 32'h00000000; IFID_Valid <= 0; IFID_PCPlus4 holds; FetchCount holds.
REQ-020 Redirect has priority over Stall when both asserted in the same cycle.
REQ-021 Instruction fetch-to-IFID latency: exactly one cycle; first valid IF/ID word appears on the first rising edge after Reset deasserts.
REQ-022 RUN to HALT on any edge where the PC value about to be used for fetch (current PC in RUN, not stalled, no redirect) is >= 4*MEM_WORDS; on that edge IF/ID <= NOP (32'h0), IFID_Valid <= 0, FetchFault <= 1, PC holds.
REQ-023 Address check also applies to a redirect target: a redirect to an out-of-range address is accepted into PC; fault raised on the next non-stalled fetch edge.
REQ-024 HALT: PC, FetchCount hold; IFID_Valid = 0, IFID_Instruction = 0; Stall and Redirect ignored; exit only by Reset.
REQ-025 PC+4 wrap from 32'hFFFFFFFC to 0 SHALL not be special-cased (range fault triggers first for any MEM_WORDS < 2^30).
REQ-026 FetchCount SHALL wrap from 32'hFFFFFFFF to 0 without flag.

Reset
REQ-027 Reset low asynchronously forces: PC = RESET_PC, state = RUN, IFID_Instruction = 0, IFID_PCPlus4 = 0, IFID_Valid = 0, FetchFault = 0, FetchCount = 0.
REQ-028 Reset asserted mid-stall, mid-redirect, or in HALT SHALL take effect immediately, independent of Clk; first fetch from RESET_PC on first rising edge with Reset high.

Verification
REQ-029 Reset release, memory word[i] = 32'h100+i, no stall -> edges 1..3 give IFID_Instruction 0x100,0x101,0x102, IFID_PCPlus4 4,8,12, FetchCount 3.
REQ-030 Stall high 2 cycles after fetching word 2 -> IF/ID holds 0x102/12, Address holds 12, FetchCount holds 3; resumes with 0x103.
REQ-031 Redirect=1, Stall=1, RedirectTarget=32'h00000043 -> next edge Address=0x40, IFID_Valid=0, IFID_Instruction=0; following edge IFID_Instruction=0x110, IFID_PCPlus4=0x44.
REQ-032 Redirect to 32'h000001FC, run 2 edges -> first edge fetches word 127 (IFID_PCPlus4=0x200); second edge FetchFault=1, IFID_Valid=0, Address stays 0x200; later Redirect ignored.
REQ-033 Assert Reset low between clock edges while in HALT -> outputs reach reset values before next edge; fetch restarts at 0.
REQ-034 Parameter MEM_WORDS=4: sequential fetch faults when Address reaches 0x10 with FetchCount=4.
